// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and parity sense constants.
package sipo_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/rx_out_buf.sv
// One-entry output holding register; a load appears on dout the cycle after the stop edge.
// Backpressure: a load while full and not draining is dropped and flagged by a one-cycle overrun pulse.
module rx_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             load_perr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             overrun
);

    logic drain;
    logic accept;

    assign drain  = dout_valid && dout_ready;
    // A drain on the same edge frees the slot, so the new word may replace the old one.
    assign accept = load && (!dout_valid || dout_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= load && !accept;
            if (accept) begin
                dout       <= load_dat;
                parity_err <= load_perr;
                dout_valid <= 1'b1;
            end else if (drain) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start, WIDTH data bits MSB first, optional parity, stop; word visible the cycle after the stop edge.
// Backpressure: one-entry buffer with valid/ready; frames arriving while it is full are dropped with an overrun pulse.
module sipo_frame_rx #(
    parameter int WIDTH      = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             framing_err,
    output logic             overrun,
    output logic             busy
);
    import sipo_frame_rx_pkg::*;

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST      = CW'(WIDTH - 1);
    localparam logic           ODD_SENSE = (PARITY_ODD != 0) ? sipo_frame_rx_pkg::PARITY_ODD
                                                             : sipo_frame_rx_pkg::PARITY_EVEN;

    rx_state_e        state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             par_bit, par_nxt;
    logic             frame_good;
    logic             frame_bad;
    logic             calc_perr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            shreg       <= shreg_nxt;
            par_bit     <= par_nxt;
            framing_err <= frame_bad;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shreg_nxt  = shreg;
        par_nxt    = par_bit;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (din) begin
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                end
            end
            DATA: begin
                shreg_nxt = {shreg[WIDTH-2:0], din};
                cnt_nxt   = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_nxt   = din;
                state_nxt = STOP;
            end
            STOP: begin
                // Line idles low, so a low stop bit marks a well-formed frame.
                frame_good = ~din;
                frame_bad  = din;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign calc_perr = (PARITY_EN != 0) ? ((^shreg) ^ par_bit ^ ODD_SENSE) : 1'b0;
    assign busy      = (state != IDLE);

    rx_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (frame_good),
        .load_dat   (shreg),
        .load_perr  (calc_perr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx (WIDTH=8, even parity) with hand-computed expected values.
module tb_sipo_frame_rx;

    logic       clk;
    logic       reset;
    logic       din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int n_chk;
    int n_err;

    sipo_frame_rx #(
        .WIDTH      (8),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one bit, let it be sampled, then settle 1ns past the edge.
    task automatic send_bit(input logic b);
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(data[i]);
        send_bit(par);
        send_bit(stop);
        din = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        reset      = 1'b0;
        din        = 1'b0;
        dout_ready = 1'b1;
        repeat (3) send_bit(1'b0);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(framing_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        send_bit(1'b0);

        // Good frame 0xA5, even parity bit 0
        send_bit(1'b1);
        check("busy_start", 32'(busy), 32'd1);
        for (int i = 7; i >= 0; i--) send_bit(logic'(8'hA5 >> i));
        send_bit(1'b0);
        send_bit(1'b0);
        din = 1'b0;
        check("good_dout", 32'(dout), 32'hA5);
        check("good_valid", 32'(dout_valid), 32'd1);
        check("good_perr", 32'(parity_err), 32'd0);
        check("good_ferr", 32'(framing_err), 32'd0);
        check("good_ovr", 32'(overrun), 32'd0);
        check("good_busy", 32'(busy), 32'd0);
        send_bit(1'b0);
        check("good_drained", 32'(dout_valid), 32'd0);

        // Parity error
        send_frame(8'hA5, 1'b1, 1'b0);
        check("perr_dout", 32'(dout), 32'hA5);
        check("perr_valid", 32'(dout_valid), 32'd1);
        check("perr_flag", 32'(parity_err), 32'd1);
        send_bit(1'b0);
        check("perr_drained", 32'(dout_valid), 32'd0);

        // Framing error: 0x3C with stop bit 1
        send_frame(8'h3C, 1'b0, 1'b1);
        check("ferr_pulse", 32'(framing_err), 32'd1);
        check("ferr_valid", 32'(dout_valid), 32'd0);
        check("ferr_dout_kept", 32'(dout), 32'hA5);
        send_bit(1'b0);
        check("ferr_pulse_end", 32'(framing_err), 32'd0);
        check("ferr_idle", 32'(busy), 32'd0);

        // Backpressure and overrun: 0xA5 then 0x5A back-to-back
        dout_ready = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0);
        check("bp_first_valid", 32'(dout_valid), 32'd1);
        check("bp_first_dout", 32'(dout), 32'hA5);
        send_frame(8'h5A, 1'b0, 1'b0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_dout_held", 32'(dout), 32'hA5);
        check("ovr_valid_held", 32'(dout_valid), 32'd1);
        check("ovr_perr_held", 32'(parity_err), 32'd0);
        send_bit(1'b0);
        check("ovr_pulse_end", 32'(overrun), 32'd0);
        check("bp_still_held", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        send_bit(1'b0);
        check("bp_delivered", 32'(dout_valid), 32'd0);
        send_bit(1'b0);
        check("bp_once", 32'(dout_valid), 32'd0);

        // Simultaneous drain and load at the stop edge of 0x0F
        dout_ready = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0);
        send_bit(1'b1);
        for (int i = 7; i >= 0; i--) send_bit(logic'(8'h0F >> i));
        send_bit(1'b0);
        check("sim_pre_dout", 32'(dout), 32'hA5);
        dout_ready = 1'b1;
        send_bit(1'b0);
        dout_ready = 1'b0;
        check("sim_ovr", 32'(overrun), 32'd0);
        check("sim_dout", 32'(dout), 32'h0F);
        check("sim_valid", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        send_bit(1'b0);
        check("sim_drained", 32'(dout_valid), 32'd0);

        // Reset mid-frame drops the partial word and the buffered word
        dout_ready = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("mid_busy", 32'(busy), 32'd1);
        din   = 1'b0;
        reset = 1'b0;
        send_bit(1'b0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'h00);
        reset      = 1'b1;
        dout_ready = 1'b1;
        send_bit(1'b0);
        send_frame(8'hC3, 1'b0, 1'b0);
        check("c3_dout", 32'(dout), 32'hC3);
        check("c3_valid", 32'(dout_valid), 32'd1);
        check("c3_perr", 32'(parity_err), 32'd0);
        check("c3_ferr", 32'(framing_err), 32'd0);
        check("c3_ovr", 32'(overrun), 32'd0);
        send_bit(1'b0);
        check("c3_drained", 32'(dout_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Downstream consumer of the serial shift-register stage.
- Takes the single-bit serial stream (one bit per clk) and detects a framed word: start bit, WIDTH data bits, optional parity bit, stop bit.
- Presents each good word in parallel through a one-entry output buffer with a valid/ready handshake, and flags parity, framing and overrun conditions.

Parameters:
- WIDTH, 8: data bits per frame (2..32).
- PARITY_EN, 1: 1 = a parity bit follows the data; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- din  input  1  serial data in, one bit per clk; line idles at 0.
- dout  output  WIDTH  received word, MSB-first assembled.
- dout_valid  output  1  dout holds an undelivered word.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready at a clk edge.
- parity_err  output  1  parity mismatch for the word in dout; qualified by dout_valid.
- framing_err  output  1  one-cycle pulse: stop bit sampled as 1, frame discarded.
- overrun  output  1  one-cycle pulse: good frame dropped because the buffer was full.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0 at an edge): state=IDLE, bit counter=0, shift reg=0, dout=0, dout_valid=0, parity_err=0, framing_err=0, overrun=0, busy=0.
  - Reset mid-frame discards the partial word.
  - Reset also drops any buffered word.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: din=1 sampled means start bit -> DATA, counter=0. din=0 -> stay in IDLE.
  - DATA: shift din into the shift register (MSB first: shreg <= {shreg[WIDTH-2:0], din}); counter++. After the WIDTH-th data bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: capture the parity bit -> STOP.
  - STOP: sample the stop bit, then -> IDLE unconditionally. A new start bit is accepted on the very next edge (back-to-back frames, no gap).
- Timing: start bit sampled at edge t; data bits at t+1..t+WIDTH; parity at t+WIDTH+1 (if enabled); stop at t+WIDTH+1+PARITY_EN. dout/dout_valid update on the stop edge, visible the cycle after.
- Parity check: calc = XOR of the data bits XOR the received parity bit XOR PARITY_ODD; parity_err = calc. With PARITY_EN=0, parity_err is always 0.
- Stop bit = 1: framing_err pulses 1 for one cycle. The word is not loaded and the buffer is untouched.
- Stop bit = 0 (good frame):
  - If dout_valid=0, or dout_valid && dout_ready at that same edge: load dout, set parity_err, dout_valid=1.
  - Else: word dropped, overrun pulses 1 for one cycle, buffered word and its parity_err unchanged.
- Handshake: dout_valid falls on an edge with dout_ready=1 unless a new word loads at that same edge. dout and parity_err are stable while dout_valid=1 and dout_ready=0.
- dout_ready is ignored when dout_valid=0.
- busy = (state != IDLE).

Decomposition:
- Shared package: FSM state encoding (2-bit enum: IDLE, DATA, PARITY, STOP) and a PARITY_EVEN/PARITY_ODD constant pair.
- Counter width is $clog2(WIDTH+1) local to the module.
- One natural sub-module: rx_out_buf, the one-entry valid/ready holding register with the overrun decision.
- The FSM and shift register stay in the top module.

Test Plan (WIDTH=8, PARITY_EN=1, PARITY_ODD=0, dout_ready=1 unless stated):
- Good frame: din = 1, 1,0,1,0,0,1,0,1, 0 (parity), 0 (stop) -> after the stop edge, dout=8'hA5, dout_valid=1 for one cycle, parity_err=0, no error pulses.
- Parity error: same frame with parity bit 1 -> dout=8'hA5, dout_valid=1, parity_err=1.
- Framing error: 0x3C frame with stop bit 1 -> framing_err pulses one cycle, dout_valid stays 0, dout keeps its previous value.
- Backpressure/overrun: dout_ready=0; send 0xA5 then 0x5A back-to-back. Expect:
  - 0x5A dropped, overrun pulses at its stop edge.
  - dout=8'hA5 held.
  - Raising dout_ready delivers 0xA5 once, then dout_valid=0.
- Simultaneous drain and load: 0xA5 buffered; dout_ready=1 exactly at the stop edge of 0x0F -> no overrun, dout=8'h0F, dout_valid stays 1.
- Reset mid-frame: reset=0 after 4 data bits, then a full 0xC3 frame -> only 0xC3 delivered, no errors, busy=0 during reset.
